// File: rtl/epcs_pkg.sv
// EPCS responder shared definitions.
// Opcodes, FSM states and small helpers.
package epcs_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_RDID      = 8'hAB;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    FDUMMY,
    DATA,
    STATUS,
    ID_DUMMY,
    ID,
    IGNORE
  } state_t;

  function automatic logic is_tx_state(state_t s);
    return s inside {DATA, STATUS, ID};
  endfunction

endpackage

// File: rtl/epcs_edge_sync.sv
// EPCS input synchronizer and edge detector.
// Brings dclk/sce/sdo into clk and flags edges.
module epcs_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dclk,
  input  logic sce,
  input  logic sdo,
  output logic sce_s,
  output logic sdo_s,
  output logic dclk_rise,
  output logic dclk_fall,
  output logic sce_rise,
  output logic sce_fall
);

  logic [SYNC_STAGES-1:0] dclk_q;
  logic [SYNC_STAGES-1:0] sce_q;
  logic [SYNC_STAGES-1:0] sdo_q;
  logic dclk_s;
  logic dclk_d;
  logic sce_d;

  // Synchronizer chains plus one delay stage for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dclk_q <= '0;
      sce_q  <= '0;
      sdo_q  <= '0;
      dclk_d <= 1'b0;
      sce_d  <= 1'b0;
    end else begin
      dclk_q <= {dclk_q[SYNC_STAGES-2:0], dclk};
      sce_q  <= {sce_q[SYNC_STAGES-2:0], sce};
      sdo_q  <= {sdo_q[SYNC_STAGES-2:0], sdo};
      dclk_d <= dclk_q[SYNC_STAGES-1];
      sce_d  <= sce_q[SYNC_STAGES-1];
    end
  end

  assign dclk_s    = dclk_q[SYNC_STAGES-1];
  assign sce_s     = sce_q[SYNC_STAGES-1];
  assign sdo_s     = sdo_q[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_d;
  assign dclk_fall = ~dclk_s & dclk_d;
  assign sce_rise  = sce_s & ~sce_d;
  assign sce_fall  = ~sce_s & sce_d;

endmodule

// File: rtl/epcs_flash_responder.sv
// EPCS serial-flash responder (READ/RDSR/RDID).
// EPCS_FAST_READ_EN adds FAST_READ (0x0B) support.
module epcs_flash_responder
  import epcs_pkg::*;
#(
  parameter int         ADDR_W      = 24,
  parameter logic [7:0] SILICON_ID  = 8'h14,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              epcs_dclk,
  input  logic              epcs_sce,
  input  logic              epcs_sdo,
  output logic              epcs_data0,
  output logic              epcs_data0_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        status_i,
  output logic              busy,
  output logic              cmd_err
);

  logic sce_s;
  logic sdo_s;
  logic dclk_rise;
  logic dclk_fall;
  logic sce_rise;
  logic sce_fall;

  state_t      state;
  state_t      state_n;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [22:0] rx;
  logic [23:0] addr_n;
  logic [7:0]  op;
  logic [7:0]  tx;
  logic [7:0]  pref;
  logic        oe_q;
  logic        rd_d;
  logic        op_bad;
  logic        byte_done;
  logic        byte_start;
  logic        go_fdummy;

  epcs_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .dclk     (epcs_dclk),
    .sce      (epcs_sce),
    .sdo      (epcs_sdo),
    .sce_s    (sce_s),
    .sdo_s    (sdo_s),
    .dclk_rise(dclk_rise),
    .dclk_fall(dclk_fall),
    .sce_rise (sce_rise),
    .sce_fall (sce_fall)
  );

  assign addr_n     = {rx, sdo_s};
  assign op         = addr_n[7:0];
  assign byte_done  = dclk_rise & (bit_cnt == 3'd7)
                    & (state != IDLE);
  assign byte_start = dclk_fall & (bit_cnt == 3'd0);

`ifdef EPCS_FAST_READ_EN
  logic fast_q;

  // Remember whether the command was FAST_READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fast_q <= 1'b0;
    end else if (state == CMD && byte_done) begin
      fast_q <= (op == OP_FAST_READ);
    end
  end

  assign go_fdummy = fast_q;
`else
  assign go_fdummy = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state; sce rise aborts from anywhere.
  always_comb begin
    state_n = state;
    op_bad  = 1'b0;
    if (sce_rise) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (sce_fall) state_n = CMD;
        CMD: if (byte_done) begin
          unique case (1'b1)
            (op == OP_READ):      state_n = ADDR;
`ifdef EPCS_FAST_READ_EN
            (op == OP_FAST_READ): state_n = ADDR;
`endif
            (op == OP_RDSR):      state_n = STATUS;
            (op == OP_RDID):      state_n = ID_DUMMY;
            default: begin
              state_n = IGNORE;
              op_bad  = 1'b1;
            end
          endcase
        end
        ADDR: if (byte_done && byte_cnt == 2'd2)
          state_n = go_fdummy ? FDUMMY : DATA;
        FDUMMY: if (byte_done) state_n = DATA;
        ID_DUMMY: if (byte_done && byte_cnt == 2'd2)
          state_n = ID;
        default: ;
      endcase
    end
  end

  // Bit/byte counting, address capture, memory and shift path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx       <= '0;
      tx       <= '0;
      pref     <= '0;
      oe_q     <= 1'b0;
      rd_d     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      rd_d    <= mem_rd;
      cmd_err <= op_bad;
      if (rd_d) pref <= mem_rdata;
      if (sce_rise) begin
        busy    <= 1'b0;
        bit_cnt <= '0;
        tx      <= '0;
        oe_q    <= 1'b0;
      end else if (sce_fall) begin
        busy     <= 1'b1;
        byte_cnt <= '0;
        bit_cnt  <= {2'b00, dclk_rise};
        if (dclk_rise) rx <= addr_n[22:0];
      end else if (state != IDLE) begin
        if (dclk_rise) begin
          rx      <= addr_n[22:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          byte_cnt <= (state == CMD) ? 2'd0
                    : byte_cnt + 2'd1;
          if (state == ADDR && byte_cnt == 2'd2) begin
            mem_addr <= addr_n[ADDR_W-1:0];
            mem_rd   <= ~go_fdummy;
          end
          if (state == FDUMMY) mem_rd <= 1'b1;
        end
        if (byte_start && is_tx_state(state)) begin
          oe_q <= 1'b1;
          unique case (state)
            DATA: begin
              tx       <= pref;
              mem_addr <= mem_addr + ADDR_W'(1);
              mem_rd   <= 1'b1;
            end
            STATUS:  tx <= status_i;
            default: tx <= SILICON_ID;
          endcase
        end else if (dclk_fall) begin
          tx <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  // Pad drive; sce high blanks the output immediately.
  always_comb begin
    epcs_data0_oe = oe_q & is_tx_state(state) & ~sce_s;
    epcs_data0    = epcs_data0_oe & tx[7];
  end

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Bench for epcs_flash_responder.
// Scoreboard queues for data bytes and read addresses.
module tb_epcs_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        epcs_dclk = 1'b0;
  logic        epcs_sce = 1'b1;
  logic        epcs_sdo = 1'b0;
  logic        epcs_data0;
  logic        epcs_data0_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  status_i = 8'h00;
  logic        busy;
  logic        cmd_err;

  int n_tests = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int err0 = 0;
  logic err_prev = 1'b0;
  logic oe_seen = 1'b0;
  logic [7:0] sh = 8'h00;
  int nb = 0;

  logic [7:0]  exp_byte[$];
  logic [23:0] exp_addr[$];

  always #5 clk = ~clk;

  epcs_flash_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .epcs_dclk    (epcs_dclk),
    .epcs_sce     (epcs_sce),
    .epcs_sdo     (epcs_sdo),
    .epcs_data0   (epcs_data0),
    .epcs_data0_oe(epcs_data0_oe),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .status_i     (status_i),
    .busy         (busy),
    .cmd_err      (cmd_err)
  );

  // memory[n] = n, one-cycle read latency
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  // read-address and cmd_err monitor
  always @(negedge clk) begin
    if (mem_rd) begin
      if (exp_addr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_rd_extra: got addr %0h required no read",
                 mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr),
              32'(exp_addr.pop_front()));
      end
    end
    if (cmd_err) begin
      err_cnt++;
      check("cmd_err_width", 32'(err_prev), 0);
    end
    err_prev = cmd_err;
  end

  // data0 monitor: master samples on dclk rise
  always @(posedge epcs_dclk or posedge epcs_sce) begin
    if (epcs_sce) begin
      nb = 0;
    end else if (epcs_data0_oe) begin
      sh = {sh[6:0], epcs_data0};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_byte.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL data_extra: got %0h required none", sh);
        end else begin
          check("data0_byte", 32'(sh), 32'(exp_byte.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) begin
      epcs_dclk = 1'b0;
      epcs_sdo  = b[i];
      tick(5);
      oe_seen = oe_seen | epcs_data0_oe;
      epcs_dclk = 1'b1;
      tick(5);
      oe_seen = oe_seen | epcs_data0_oe;
    end
  endtask

  task automatic begin_txn();
    epcs_sce = 1'b0;
    oe_seen  = 1'b0;
    tick(5);
  endtask

  task automatic end_txn();
    epcs_sce = 1'b1;
    tick(5);
    epcs_dclk = 1'b0;
    tick(5);
  endtask

  task automatic drained(input string name);
    check({name, "_rd_left"}, 32'(exp_addr.size()), 0);
    check({name, "_data_left"}, 32'(exp_byte.size()), 0);
  endtask

  initial begin
    tick(4);
    check("rst_data0", 32'(epcs_data0), 0);
    check("rst_oe", 32'(epcs_data0_oe), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);
    rst_n = 1'b1;
    tick(6);

    // READ 0x10, 3 bytes
    for (int k = 0; k < 4; k++) exp_addr.push_back(24'h10 + 24'(k));
    for (int k = 0; k < 3; k++) exp_byte.push_back(8'h10 + 8'(k));
    begin_txn();
    check("busy_active", 32'(busy), 1);
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h10);
    check("read_oe_cmd", 32'(oe_seen), 0);
    repeat (3) xfer(8'h00);
    end_txn();
    check("busy_idle", 32'(busy), 0);
    drained("read");

    // READ wrap at 0xFFFFFF
    exp_addr.push_back(24'hFFFFFF);
    exp_addr.push_back(24'h000000);
    exp_addr.push_back(24'h000001);
    exp_byte.push_back(8'hFF);
    exp_byte.push_back(8'h00);
    begin_txn();
    xfer(8'h03); xfer(8'hFF); xfer(8'hFF); xfer(8'hFF);
    repeat (2) xfer(8'h00);
    end_txn();
    drained("wrap");

    // READ_STATUS, status changes during byte 1
    status_i = 8'h01;
    exp_byte.push_back(8'h01);
    exp_byte.push_back(8'h00);
    begin_txn();
    xfer(8'h05);
    check("status_oe_cmd", 32'(oe_seen), 0);
    oe_seen = 1'b0;
    fork
      begin
        tick(20);
        status_i = 8'h00;
      end
    join_none
    xfer(8'h00);
    check("status_oe_data", 32'(oe_seen), 1);
    xfer(8'h00);
    end_txn();
    drained("status");

    // READ_ID
    exp_byte.push_back(8'h14);
    exp_byte.push_back(8'h14);
    begin_txn();
    xfer(8'hAB);
    repeat (3) xfer(8'h00);
    check("id_oe_dummy", 32'(oe_seen), 0);
    repeat (2) xfer(8'h00);
    end_txn();
    drained("id");

    // unsupported opcode, then normal READ
    err0 = err_cnt;
    begin_txn();
    xfer(8'h9F); xfer(8'h00); xfer(8'h00);
    end_txn();
    check("bad_cmd_err", 32'(err_cnt - err0), 1);
    check("bad_oe", 32'(oe_seen), 0);
    exp_addr.push_back(24'h05);
    exp_addr.push_back(24'h06);
    exp_byte.push_back(8'h05);
    begin_txn();
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h05);
    xfer(8'h00);
    end_txn();
    drained("after_bad");

    // sce raised after 4 bits of a DATA byte
    exp_addr.push_back(24'h70);
    exp_addr.push_back(24'h71);
    exp_addr.push_back(24'h72);
    exp_byte.push_back(8'h70);
    begin_txn();
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h70);
    xfer(8'h00);
    xfer(8'h00, 4);
    check("abort_pre_data0", 32'(epcs_data0), 1);
    epcs_sce = 1'b1;
    tick(3);
    check("abort_oe", 32'(epcs_data0_oe), 0);
    check("abort_data0", 32'(epcs_data0), 0);
    tick(2);
    epcs_dclk = 1'b0;
    tick(5);
    drained("abort");

    // rst_n pulse mid ADDR; later bits must be ignored
    err0 = err_cnt;
    begin_txn();
    xfer(8'h03); xfer(8'h00);
    fork
      begin
        tick(23);
        rst_n = 1'b0;
        tick(1);
        check("rst_mid_oe", 32'(epcs_data0_oe), 0);
        check("rst_mid_data0", 32'(epcs_data0), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_addr", 32'(mem_addr), 0);
        rst_n = 1'b1;
      end
    join_none
    xfer(8'h00);
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h00);
    check("rst_mid_idle_oe", 32'(oe_seen), 0);
    end_txn();
    check("rst_mid_err", 32'(err_cnt - err0), 0);
    drained("rst_mid");

`ifdef EPCS_FAST_READ_EN
    exp_addr.push_back(24'h20);
    exp_addr.push_back(24'h21);
    exp_byte.push_back(8'h20);
    begin_txn();
    xfer(8'h0B); xfer(8'h00); xfer(8'h00); xfer(8'h20);
    xfer(8'h00);
    check("fast_oe_dummy", 32'(oe_seen), 0);
    xfer(8'h00);
    end_txn();
    drained("fast");
`else
    err0 = err_cnt;
    begin_txn();
    xfer(8'h0B); xfer(8'h00);
    end_txn();
    check("fast_off_err", 32'(err_cnt - err0), 1);
    drained("fast_off");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
